// File: rtl/fp_sink_pkg.sv
// Shared types and constants for the FPU result sink.
package fp_sink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sink_state_e;

    localparam int STATUS_W = 5;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;

endpackage

// File: rtl/sink_lfsr.sv
// 16-bit Fibonacci LFSR that produces the backpressure stall decision.
// It shifts left with the XOR of the tapped bits entering at bit 0, and it
// holds its value whenever i_en is low.
module sink_lfsr
    import fp_sink_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_stall
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);
    assign o_stall    = (r_lfsr[1:0] == 2'b00);

    // Advance the sequence only while the sink is actively consuming.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

endmodule

// File: rtl/fp_result_sink.sv
// Consumer for the FPU output handshake. It accepts NUM_RESULTS results,
// folds each one into a MISR signature, ORs the status flags together,
// then waits END_DELAY cycles and raises end_sim_o.
// Optional macro FP_SINK_BACKPRESSURE_EN adds LFSR-driven ready stalls.
module fp_result_sink
    import fp_sink_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       NUM_RESULTS = 16,
    parameter int unsigned       END_DELAY   = 10,
    parameter logic [WIDTH-1:0]  MISR_POLY   = WIDTH'(MISR_POLY_DEFAULT),
    parameter logic [15:0]       LFSR_SEED   = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [WIDTH-1:0]    result_i,
    input  logic [STATUS_W-1:0] status_i,
    input  logic                tag_i,
    output logic [15:0]         count_o,
    output logic [STATUS_W-1:0] status_acc_o,
    output logic [WIDTH-1:0]    signature_o,
    output logic [WIDTH-1:0]    last_result_o,
    output logic                last_tag_o,
    output logic                done_o,
    output logic                end_sim_o
);

    localparam bit          NO_RESULTS = (NUM_RESULTS == 0);
    localparam logic [15:0] LAST_IDX   = NO_RESULTS ? 16'd0 : 16'(NUM_RESULTS - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(END_DELAY - 1);

    sink_state_e         r_state;
    sink_state_e         w_nextState;
    logic [15:0]         r_count;
    logic [STATUS_W-1:0] r_statusAcc;
    logic [WIDTH-1:0]    r_signature;
    logic [WIDTH-1:0]    r_lastResult;
    logic                r_lastTag;
    logic [15:0]         r_drainCnt;

    logic             w_inRun;
    logic             w_stall;
    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_sigNext;

    assign w_inRun = (r_state == RUN);

`ifdef FP_SINK_BACKPRESSURE_EN
    sink_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_en    (w_inRun),
        .o_stall (w_stall)
    );
`else
    assign w_stall = 1'b0;
`endif

    // Ready is decoded purely from registered state so valid_i never loops back.
    assign w_ready  = w_inRun & ~w_stall;
    assign w_accept = valid_i & w_ready;

    assign w_sigNext = {r_signature[WIDTH-2:0], 1'b0}
                     ^ (r_signature[WIDTH-1] ? MISR_POLY : '0)
                     ^ result_i;

    assign ready_o       = w_ready;
    assign count_o       = r_count;
    assign status_acc_o  = r_statusAcc;
    assign signature_o   = r_signature;
    assign last_result_o = r_lastResult;
    assign last_tag_o    = r_lastTag;
    assign done_o        = (r_state == DRAIN) || (r_state == DONE);
    assign end_sim_o     = (r_state == DONE);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; leaving RUN on the final accept keeps ready low afterwards.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_nextState = NO_RESULTS ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (w_accept && (r_count == LAST_IDX)) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drainCnt == DRAIN_LAST) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = DONE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Capture and compress every accepted result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count      <= '0;
            r_statusAcc  <= '0;
            r_signature  <= '0;
            r_lastResult <= '0;
            r_lastTag    <= 1'b0;
        end else if (w_accept) begin
            r_count      <= r_count + 16'd1;
            r_statusAcc  <= r_statusAcc | status_i;
            r_signature  <= w_sigNext;
            r_lastResult <= result_i;
            r_lastTag    <= tag_i;
        end
    end

    // Count cycles spent draining before the end-of-simulation strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drainCnt <= '0;
        end else if (r_state == DRAIN) begin
            r_drainCnt <= r_drainCnt + 16'd1;
        end
    end

endmodule
